corsel_rr_sched: RTL and testbench

Round-robin scheduler that shares one two-stage correction-select pipeline among NUM_REQ digit-channel requesters in the TPU datapath. It accepts operand/sign-flag pairs over per-requester valid/ready handshakes and issues at most one per cycle into the shared unit. It tracks requester IDs alongside the fixed 2-cycle pipeline and collects results into a credit-protected response FIFO with backpressure.

---
 rtl/corsel_rr_sched.sv | 207 ++++++++++++++++++++
 tb/tb_corsel_rr_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corsel_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : corsel_rr_sched
//  Purpose  : Round-robin scheduler in front of a shared two-stage
//             correction-select unit. Grants at most one requester per cycle,
//             registers the winning operand/sign pair into the unit, carries
//             the requester ID alongside the unit's fixed 2-cycle latency and
//             collects results in a credit-protected show-ahead response FIFO.
//  Ports    : clk, reset_n (async, active-low)
//             req_valid/req_ready/req_data/req_sign : per-requester handshake
//             cs_A/cs_sign  -> shared unit (registered)
//             cs_A_out/cs_cor <- shared unit (2 cycles after cs_A)
//             rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_cor : response FIFO head
//             idle : no request accepted and not yet popped
//  Revision : 1.0  initial release
// ============================================================================
module corsel_rr_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]          req_sign,
    output logic [DATA_WIDTH-1:0]         cs_A,
    output logic [1:0]                    cs_sign,
    input  logic [DATA_WIDTH-1:0]         cs_A_out,
    input  logic [DATA_WIDTH-1:0]         cs_cor,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [DATA_WIDTH-1:0]         rsp_cor,
    output logic                          idle
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = ID_W + 2 * DATA_WIDTH;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ID_W-1:0]   r_ptr;       // last granted requester
    logic [CNT_W-1:0]  r_occ;       // accepted but not yet popped
    logic              r_tag0_v;    // tag travelling with cs_A
    logic [ID_W-1:0]   r_tag0_id;
    logic              r_tag1_v;    // unit stage 1
    logic [ID_W-1:0]   r_tag1_id;
    logic              r_tag2_v;    // unit stage 2 (aligned with cs_A_out)
    logic [ID_W-1:0]   r_tag2_id;

    logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic              w_found;
    logic [ID_W-1:0]   w_gnt_id;
    int                w_idx;
    logic              w_pop;
    logic              w_credit;
    logic              w_xfer;
    logic [DATA_WIDTH-1:0] w_data;
    logic [1:0]        w_sign;
    logic              w_fifo_wr;
    logic              w_full;
    logic [ENT_W-1:0]  w_head;

    // Circular search starting one past the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && req_valid[ID_W'(w_idx)]) begin
                w_found  = 1'b1;
                w_gnt_id = ID_W'(w_idx);
            end
        end
    end

    assign rsp_valid = (r_count != '0);
    assign w_pop     = rsp_valid & rsp_ready;
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));

    // A pop in the same cycle frees the slot the new request will need.
    assign w_credit  = (r_occ < CNT_W'(FIFO_DEPTH)) | w_pop;
    // reset_n gating keeps req_ready low for the whole reset interval.
    assign w_xfer    = w_found & w_credit & reset_n;

    always_comb begin
        req_ready = '0;
        if (w_xfer) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    always_comb begin
        w_data = '0;
        w_sign = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_id == ID_W'(i)) begin
                w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sign = req_sign[i*2 +: 2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbiter pointer, credit counter, issue register and tag pipe
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr     <= ID_W'(NUM_REQ - 1);
            r_occ     <= '0;
            cs_A      <= '0;
            cs_sign   <= '0;
            r_tag0_v  <= 1'b0;
            r_tag0_id <= '0;
            r_tag1_v  <= 1'b0;
            r_tag1_id <= '0;
            r_tag2_v  <= 1'b0;
            r_tag2_id <= '0;
        end else begin
            case ({w_xfer, w_pop})
                2'b10:   r_occ <= r_occ + CNT_W'(1);
                2'b01:   r_occ <= r_occ - CNT_W'(1);
                default: r_occ <= r_occ;
            endcase

            // Bubbles drive zero so the unit returns cor = 0 for them.
            if (w_xfer) begin
                r_ptr     <= w_gnt_id;
                cs_A      <= w_data;
                cs_sign   <= w_sign;
                r_tag0_v  <= 1'b1;
                r_tag0_id <= w_gnt_id;
            end else begin
                cs_A      <= '0;
                cs_sign   <= '0;
                r_tag0_v  <= 1'b0;
                r_tag0_id <= '0;
            end

            r_tag1_v  <= r_tag0_v;
            r_tag1_id <= r_tag0_id;
            r_tag2_v  <= r_tag1_v;
            r_tag2_id <= r_tag1_id;
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO (show-ahead)
    // ------------------------------------------------------------------
    assign w_fifo_wr = r_tag2_v;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_fifo_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_mem[r_wr_ptr] <= {r_tag2_id, cs_A_out, cs_cor};
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
        w_fifo_wr |-> (!w_full || w_pop));

    assign w_head   = r_mem[r_rd_ptr];
    assign rsp_id   = rsp_valid ? w_head[ENT_W-1 -: ID_W]             : '0;
    assign rsp_data = rsp_valid ? w_head[2*DATA_WIDTH-1 -: DATA_WIDTH] : '0;
    assign rsp_cor  = rsp_valid ? w_head[DATA_WIDTH-1:0]               : '0;

    assign idle = (r_occ == '0);

endmodule
`default_nettype wire

// File: tb/tb_corsel_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_corsel_rr_sched
//  Purpose  : Self-checking bench for corsel_rr_sched. Includes a behavioural
//             shared correction-select unit (2-cycle latency, cor = 5 for any
//             non-zero sign pair) and a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_corsel_rr_sched;

    localparam int NR = 4;
    localparam int DW = 18;
    localparam int FD = 4;
    localparam logic [DW-1:0] DIGIT_CORRECT = 18'd5;

    logic               clk;
    logic               reset_n;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*DW-1:0]   req_data;
    logic [NR*2-1:0]    req_sign;
    logic [DW-1:0]      cs_A;
    logic [1:0]         cs_sign;
    logic [DW-1:0]      cs_A_out;
    logic [DW-1:0]      cs_cor;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [1:0]         rsp_id;
    logic [DW-1:0]      rsp_data;
    logic [DW-1:0]      rsp_cor;
    logic               idle;

    corsel_rr_sched #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_sign  (req_sign),
        .cs_A      (cs_A),
        .cs_sign   (cs_sign),
        .cs_A_out  (cs_A_out),
        .cs_cor    (cs_cor),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_cor   (rsp_cor),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared unit: samples one edge after issue, presents one edge later.
    logic [DW-1:0] u1_a = '0;
    logic [1:0]    u1_s = '0;
    logic [DW-1:0] u2_a = '0;
    logic [DW-1:0] u2_c = '0;
    always @(posedge clk) begin
        u1_a <= cs_A;
        u1_s <= cs_sign;
        u2_a <= u1_a;
        u2_c <= (u1_s != 2'b00) ? DIGIT_CORRECT : '0;
    end
    assign cs_A_out = u2_a;
    assign cs_cor   = u2_c;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] data;
        logic [DW-1:0] cor;
        int            due;
    } rsp_t;

    rsp_t          sbq[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            n_pop = 0;
    int            n_disc = 0;
    int            dut_xfers = 0;
    bit            pop_now = 1'b0;
    int            mptr = NR - 1;
    logic          v [NR];
    logic [DW-1:0] d [NR];
    logic [1:0]    s [NR];
    logic          rr;
    logic [DW-1:0] exp_csa;
    logic [1:0]    exp_css;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands over a response.
    initial begin
        rsp_t h;
        bit   exp_v;
        forever begin
            @(negedge clk);
            #2;
            exp_v = (sbq.size() > 0) && (sbq[0].due <= cyc);
            check("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_v});
            check("idle", {63'd0, idle}, {63'd0, sbq.size() == 0});
            pop_now = 1'b0;
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
                end else begin
                    h = sbq.pop_front();
                    check("rsp_id", {62'd0, rsp_id}, {62'd0, h.id});
                    check("rsp_data", {46'd0, rsp_data}, {46'd0, h.data});
                    check("rsp_cor", {46'd0, rsp_cor}, {46'd0, h.cor});
                    pop_now = 1'b1;
                    n_pop++;
                end
            end
        end
    end

    // One clock of stimulus: drive at negedge, predict the grant before the
    // edge, and check the registered issue outputs after it.
    task automatic step();
        logic [NR-1:0] exp_rdy;
        int            win;
        int            idx;
        bit            credit;
        rsp_t          e;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = v[i];
            req_data[i*DW +: DW] = d[i];
            req_sign[i*2 +: 2]   = s[i];
        end
        rsp_ready = rr;
        #4;
        credit = ((sbq.size() + (pop_now ? 1 : 0)) < FD) || pop_now;
        win = -1;
        for (int k = 1; k <= NR; k++) begin
            idx = (mptr + k) % NR;
            if (win < 0 && v[idx]) win = idx;
        end
        exp_rdy = '0;
        if (win >= 0 && credit) exp_rdy = NR'(1) << win;
        check("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
        if ((req_valid & req_ready) != '0) dut_xfers++;
        if (win >= 0 && credit) begin
            e.id   = 2'(win);
            e.data = d[win];
            e.cor  = (s[win] != 2'b00) ? DIGIT_CORRECT : '0;
            e.due  = cyc + 4;
            sbq.push_back(e);
            v[win]  = 1'b0;
            mptr    = win;
            exp_csa = d[win];
            exp_css = s[win];
        end else begin
            exp_csa = '0;
            exp_css = '0;
        end
        @(posedge clk);
        #1;
        check("cs_A", {46'd0, cs_A}, {46'd0, exp_csa});
        check("cs_sign", {62'd0, cs_sign}, {62'd0, exp_css});
    endtask

    task automatic load(input int i, input logic [DW-1:0] data, input logic [1:0] sign);
        v[i] = 1'b1;
        d[i] = data;
        s[i] = sign;
    endtask

    task automatic drain();
        int k;
        rr = 1'b1;
        k  = 0;
        while (k < 40 && (sbq.size() != 0 || v[0] || v[1] || v[2] || v[3])) begin
            step();
            k++;
        end
        step();
        check("drain_idle", {63'd0, idle}, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {60'd0, req_ready}, 64'd0);
        check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        check({tag, "_idle"}, {63'd0, idle}, 64'd1);
        check({tag, "_cs_A"}, {46'd0, cs_A}, 64'd0);
        check({tag, "_cs_sign"}, {62'd0, cs_sign}, 64'd0);
        check({tag, "_rsp_id"}, {62'd0, rsp_id}, 64'd0);
        check({tag, "_rsp_data"}, {46'd0, rsp_data}, 64'd0);
        check({tag, "_rsp_cor"}, {46'd0, rsp_cor}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int base;
        reset_n   = 1'b0;
        req_valid = '1;
        req_data  = '0;
        req_sign  = '0;
        rsp_ready = 1'b0;
        rr        = 1'b0;
        for (int i = 0; i < NR; i++) begin
            v[i] = 1'b0; d[i] = '0; s[i] = '0;
        end
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        req_valid = '0;

        // Single request from requester 2.
        rr = 1'b1;
        load(2, 18'h00123, 2'b01);
        step();
        drain();

        // Round robin with all requesters valid.
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < NR; i++)
                if (!v[i]) load(i, DW'($urandom), 2'b00);
            step();
        end
        drain();

        // Backpressure: requester 0 streams into a stalled consumer.
        rr   = 1'b0;
        base = dut_xfers;
        for (int c = 0; c < 8; c++) begin
            if (!v[0]) load(0, DW'($urandom), 2'($urandom));
            step();
        end
        check("bp_transfers", 64'(dut_xfers - base), 64'd4);
        rr   = 1'b1;
        base = dut_xfers;
        step();
        check("bp_pop_admits_one", 64'(dut_xfers - base), 64'd1);
        rr   = 1'b0;
        base = dut_xfers;
        if (!v[0]) load(0, DW'($urandom), 2'($urandom));
        step();
        step();
        check("bp_blocked_again", 64'(dut_xfers - base), 64'd0);
        drain();

        // Bubbles: requester 1 valid on alternate cycles.
        for (int c = 0; c < 12; c++) begin
            if (c % 2 == 0 && !v[1]) load(1, DW'($urandom), 2'($urandom));
            step();
        end
        drain();

        // Reset mid-stream with one response queued and more in flight.
        rr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (!v[3]) load(3, DW'($urandom), 2'b11);
            step();
        end
        @(negedge clk);
        req_valid = '1;
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        n_disc += sbq.size();
        sbq.delete();
        mptr = NR - 1;
        for (int i = 0; i < NR; i++) v[i] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        req_valid = '0;
        rr        = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NR; i++)
                if (!v[i]) load(i, DW'($urandom), 2'b00);
            step();
        end
        drain();

        // Sign combinations.
        load(0, 18'h2AAAA, 2'b10); step();
        load(1, 18'h15555, 2'b11); step();
        load(2, 18'h3FFFF, 2'b00); step();
        drain();

        // Randomised traffic with random consumer stalls.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++)
                if (!v[i] && ($urandom_range(0, 1) == 1))
                    load(i, DW'($urandom), 2'($urandom));
            rr = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();

        check("response_count", 64'(n_pop + n_disc), 64'(dut_xfers));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
